// File: rtl/cdb_pkg.sv
// Shared CDB definitions: bus widths, reservation-station tag bases and the
// round-robin pick helper used by the CDB arbiter.
package cdb_pkg;

    localparam int WORD_SIZE = 32;
    localparam int UNIT_SIZE = 8;

    localparam logic [7:0] TAG_SW        = 8'h00;
    localparam logic [7:0] TAG_ADD       = 8'h20;
    localparam logic [7:0] TAG_MUL       = 8'h40;
    localparam logic [7:0] TAG_LW        = 8'h80;
    localparam logic [7:0] TAG_REG_READY = 8'h7F;

    localparam int MAX_REQ = 32;
    localparam int IDX_W   = 5;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of req_mask at or after ptr, wrapping modulo num_req.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req_mask,
                                         input logic [IDX_W-1:0]   ptr,
                                         input int unsigned        num_req);
        rr_pick_t    res;
        int unsigned j;
        res = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (i < num_req) begin
                j = 32'(ptr) + i;
                if (j >= num_req) j = j - num_req;
                if (!res.found && req_mask[j]) begin
                    res.found = 1'b1;
                    res.idx   = j[IDX_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/cdb_req_fifo.sv
// Per-requester completion FIFO: wrap-around read/write pointers plus an
// occupancy count; head is the oldest stored {tag, result}.
module cdb_req_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push & ~full & ~flush;
    assign pop_ok  = pop & ~empty & ~flush;

    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
            else if (pop_ok && !push_ok) count_d = count_q - CNT_W'(1);
        end
    end

    // NOTE: state flops use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; an empty count makes its contents unobservable.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-requester FIFOs feed a round-robin grant that
// drives a registered one-result-per-cycle CDB broadcast.
module cdb_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int UNIT_SIZE  = cdb_pkg::UNIT_SIZE,
    parameter int WORD_SIZE  = cdb_pkg::WORD_SIZE,
    localparam int SRC_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*UNIT_SIZE-1:0]   req_tag,
    input  logic [NUM_REQ*WORD_SIZE-1:0]   req_data,
    output logic                           cdb_valid,
    output logic [UNIT_SIZE-1:0]           cdb_tag,
    output logic [WORD_SIZE-1:0]           cdb_data,
    output logic [SRC_W-1:0]               cdb_src,
    output logic                           busy,
    output logic                           err_tag
);

    import cdb_pkg::*;

    localparam int ENTRY_W = UNIT_SIZE + WORD_SIZE;

    logic [NUM_REQ-1:0] fifo_full, fifo_empty, tag_reserved, push, pop;
    logic [ENTRY_W-1:0] fifo_head [NUM_REQ];

    logic [MAX_REQ-1:0] req_mask;
    rr_pick_t           pick;
    logic [SRC_W-1:0]   grant_src, grant_next;
    logic [ENTRY_W-1:0] grant_head;

    logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                 cdb_valid_q, cdb_valid_d;
    logic [UNIT_SIZE-1:0] cdb_tag_q, cdb_tag_d;
    logic [WORD_SIZE-1:0] cdb_data_q, cdb_data_d;
    logic [SRC_W-1:0]     cdb_src_q, cdb_src_d;
    logic                 err_tag_q, err_tag_d;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_req
        // Reserved-tag pushes complete the handshake but are never stored.
        assign tag_reserved[k] =
            (req_tag[k*UNIT_SIZE +: UNIT_SIZE] == UNIT_SIZE'(TAG_REG_READY));
        assign push[k] = req_valid[k] & ~fifo_full[k] & ~tag_reserved[k] & ~flush;

        cdb_req_fifo #(
            .WIDTH (ENTRY_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .flush (flush),
            .push  (push[k]),
            .pop   (pop[k]),
            .din   ({req_tag[k*UNIT_SIZE +: UNIT_SIZE], req_data[k*WORD_SIZE +: WORD_SIZE]}),
            .full  (fifo_full[k]),
            .empty (fifo_empty[k]),
            .head  (fifo_head[k])
        );
    end

    always_comb begin
        req_mask              = '0;
        req_mask[NUM_REQ-1:0] = ~fifo_empty;
        pick                  = rr_pick(req_mask, IDX_W'(rr_ptr_q), NUM_REQ);
        pop                   = '0;
        grant_src             = '0;
        grant_next            = '0;
        grant_head            = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick.found && pick.idx == IDX_W'(k)) begin
                pop[k]     = ~flush;
                grant_src  = SRC_W'(k);
                grant_next = SRC_W'((k + 1) % NUM_REQ);
                grant_head = fifo_head[k];
            end
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = 1'b0;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        cdb_src_d   = cdb_src_q;
        err_tag_d   = err_tag_q;
        if (flush) begin
            rr_ptr_d = '0;
        end else begin
            if (|(req_valid & ~fifo_full & tag_reserved)) err_tag_d = 1'b1;
            if (pick.found) begin
                cdb_valid_d = 1'b1;
                cdb_tag_d   = grant_head[ENTRY_W-1 -: UNIT_SIZE];
                cdb_data_d  = grant_head[WORD_SIZE-1:0];
                cdb_src_d   = grant_src;
                rr_ptr_d    = grant_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
            err_tag_q   <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_src_q   <= cdb_src_d;
            err_tag_q   <= err_tag_d;
        end
    end

    assign req_ready = ~fifo_full;
    assign busy      = (|(~fifo_empty)) | cdb_valid_q;
    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;
    assign cdb_src   = cdb_src_q;
    assign err_tag   = err_tag_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and randomized checks of cdb_arbiter against a queue-based model
// of the CDB sharing rules.
module tb_cdb_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DEPTH   = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [31:0]  req_tag = '0;
    logic [127:0] req_data = '0;
    logic         cdb_valid;
    logic [7:0]   cdb_tag;
    logic [31:0]  cdb_data;
    logic [1:0]   cdb_src;
    logic         busy;
    logic         err_tag;

    cdb_arbiter #(.NUM_REQ(NUM_REQ), .FIFO_DEPTH(DEPTH), .UNIT_SIZE(8), .WORD_SIZE(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src),
        .busy      (busy),
        .err_tag   (err_tag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  tag;
        logic [31:0] data;
    } ent_t;

    ent_t        mq [NUM_REQ][$];
    int          m_rr;
    logic        m_valid;
    logic [7:0]  m_tag;
    logic [31:0] m_data;
    logic [1:0]  m_src;
    logic        m_err;
    logic [3:0]  last_acc;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    endtask

    task automatic m_reset();
        for (int k = 0; k < NUM_REQ; k++) mq[k].delete();
        m_rr    = 0;
        m_valid = 1'b0;
        m_tag   = '0;
        m_data  = '0;
        m_src   = '0;
        m_err   = 1'b0;
    endtask

    function automatic logic m_busy();
        logic b;
        b = m_valid;
        for (int k = 0; k < NUM_REQ; k++) if (mq[k].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic set_req(input int k, input logic [7:0] tag, input logic [31:0] data);
        req_valid[k]       = 1'b1;
        req_tag[k*8 +: 8]  = tag;
        req_data[k*32 +: 32] = data;
    endtask

    // One clock: check ready, advance the model, then compare the registered outputs.
    task automatic cycle();
        logic [3:0] exp_ready;
        int         g;
        ent_t       e;
        for (int k = 0; k < NUM_REQ; k++) exp_ready[k] = (mq[k].size() < DEPTH);
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        last_acc = '0;
        if (flush) begin
            for (int k = 0; k < NUM_REQ; k++) mq[k].delete();
            m_valid = 1'b0;
            m_rr    = 0;
        end else begin
            g = -1;
            for (int i = 0; i < NUM_REQ; i++)
                if (g < 0 && mq[(m_rr + i) % NUM_REQ].size() > 0) g = (m_rr + i) % NUM_REQ;
            if (g >= 0) begin
                e       = mq[g].pop_front();
                m_valid = 1'b1;
                m_tag   = e.tag;
                m_data  = e.data;
                m_src   = 2'(g);
                m_rr    = (g + 1) % NUM_REQ;
            end else begin
                m_valid = 1'b0;
            end
            for (int k = 0; k < NUM_REQ; k++) begin
                if (req_valid[k] && exp_ready[k]) begin
                    last_acc[k] = 1'b1;
                    if (req_tag[k*8 +: 8] == 8'h7F) m_err = 1'b1;
                    else mq[k].push_back('{tag: req_tag[k*8 +: 8], data: req_data[k*32 +: 32]});
                end
            end
        end
        @(posedge clk);
        #1;
        check("cdb_valid", 64'(cdb_valid), 64'(m_valid));
        check("cdb_tag",   64'(cdb_tag),   64'(m_tag));
        check("cdb_data",  64'(cdb_data),  64'(m_data));
        check("cdb_src",   64'(cdb_src),   64'(m_src));
        check("busy",      64'(busy),      64'(m_busy()));
        check("err_tag",   64'(err_tag),   64'(m_err));
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        req_valid = '0;
        m_reset();
        @(negedge clk);
        check("rst_cdb_valid", 64'(cdb_valid), 64'(0));
        check("rst_cdb_tag",   64'(cdb_tag),   64'(0));
        check("rst_cdb_data",  64'(cdb_data),  64'(0));
        check("rst_cdb_src",   64'(cdb_src),   64'(0));
        check("rst_busy",      64'(busy),      64'(0));
        check("rst_err_tag",   64'(err_tag),   64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'(4'hF));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  grant_seq [$];
        logic [31:0] lw_seen [$];
        int          acc2;
        logic        saw_low;

        // 1: single push, two-edge latency, one pulse
        apply_reset();
        set_req(1, 8'h41, 32'd7);
        cycle();
        req_valid = '0;
        check("t1_no_early_valid", 64'(cdb_valid), 64'(0));
        cycle();
        check("t1_valid", 64'(cdb_valid), 64'(1));
        check("t1_tag",   64'(cdb_tag),   64'(8'h41));
        check("t1_data",  64'(cdb_data),  64'(7));
        check("t1_src",   64'(cdb_src),   64'(1));
        cycle();
        check("t1_single_pulse", 64'(cdb_valid), 64'(0));
        check("t1_busy_low",     64'(busy),      64'(0));

        // 2: all requesters at once from rr_ptr=0
        apply_reset();
        set_req(0, 8'h20, $urandom());
        set_req(1, 8'h40, $urandom());
        set_req(2, 8'h80, $urandom());
        set_req(3, 8'h21, $urandom());
        cycle();
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("t2_valid", 64'(cdb_valid), 64'(1));
            check("t2_src",   64'(cdb_src),   64'(i));
        end
        cycle();
        check("t2_idle", 64'(cdb_valid), 64'(0));
        set_req(3, 8'h22, 32'h33);
        set_req(1, 8'h42, 32'h11);
        cycle();
        req_valid = '0;
        cycle();
        check("t2_rr_wrapped_src", 64'(cdb_src), 64'(1));
        cycle();
        check("t2_rr_next_src", 64'(cdb_src), 64'(3));
        cycle();

        // 3: lw stream against an always-valid add requester
        acc2    = 0;
        saw_low = 1'b0;
        for (int c = 0; c < 24; c++) begin
            if (c < 14) set_req(0, 8'h20, 32'h1000 + 32'(c));
            else req_valid[0] = 1'b0;
            if (acc2 < 5) set_req(2, 8'h80 + 8'(acc2), 32'h100 + 32'(acc2));
            else req_valid[2] = 1'b0;
            if (req_valid[2] && req_ready[2] === 1'b0) saw_low = 1'b1;
            cycle();
            if (last_acc[2]) acc2++;
            if (cdb_valid) begin
                grant_seq.push_back(cdb_src);
                if (cdb_src == 2'd2) lw_seen.push_back(cdb_data);
            end
        end
        req_valid = '0;
        check("t3_ready2_dropped", 64'(saw_low), 64'(1));
        check("t3_grant0", 64'(grant_seq[0]), 64'(0));
        check("t3_grant1", 64'(grant_seq[1]), 64'(2));
        check("t3_grant2", 64'(grant_seq[2]), 64'(0));
        check("t3_grant3", 64'(grant_seq[3]), 64'(2));
        check("t3_lw_count", 64'(lw_seen.size()), 64'(5));
        for (int i = 0; i < 5 && i < lw_seen.size(); i++)
            check("t3_lw_order", 64'(lw_seen[i]), 64'(32'h100 + 32'(i)));

        // 4: reserved tag is swallowed and sets sticky err_tag
        set_req(3, 8'h7F, 32'hDEAD);
        cycle();
        req_valid = '0;
        cycle();
        check("t4_no_bcast", 64'(cdb_valid), 64'(0));
        check("t4_err_set",  64'(err_tag),   64'(1));
        cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        cycle();
        check("t4_err_after_flush", 64'(err_tag), 64'(1));

        // 5: flush with three FIFOs holding entries, rr_ptr advanced
        set_req(0, 8'h20, 32'hA0);
        set_req(1, 8'h40, 32'hA1);
        set_req(2, 8'h80, 32'hA2);
        cycle();
        set_req(0, 8'h23, 32'hB0);
        set_req(1, 8'h43, 32'hB1);
        set_req(2, 8'h83, 32'hB2);
        cycle();
        req_valid = '0;
        flush = 1'b1;
        set_req(3, 8'h24, 32'hDD);
        cycle();
        flush = 1'b0;
        req_valid = '0;
        check("t5_valid_low", 64'(cdb_valid), 64'(0));
        check("t5_busy_low",  64'(busy),      64'(0));
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t5_no_stale", 64'(cdb_valid), 64'(0));
        end
        set_req(0, 8'h25, 32'hC0);
        set_req(1, 8'h45, 32'hC1);
        cycle();
        req_valid = '0;
        cycle();
        check("t5_rr_reset_src",  64'(cdb_src),  64'(0));
        check("t5_rr_reset_data", 64'(cdb_data), 64'(32'hC0));
        cycle();
        check("t5_second_src", 64'(cdb_src), 64'(1));
        cycle();

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            flush = ($urandom_range(0, 49) == 0);
            for (int k = 0; k < NUM_REQ; k++) begin
                if ($urandom_range(0, 2) != 0) set_req(k, 8'($urandom_range(0, 255)), $urandom());
                else req_valid[k] = 1'b0;
            end
            cycle();
        end
        flush = 1'b0;

        // 6: asynchronous reset mid-burst
        set_req(0, 8'h7F, 32'h1);
        set_req(1, 8'h46, 32'h2);
        set_req(2, 8'h86, 32'h3);
        set_req(3, 8'h26, 32'h4);
        cycle();
        set_req(0, 8'h27, 32'h5);
        cycle();
        check("t6_busy_before", 64'(busy),    64'(1));
        check("t6_err_before",  64'(err_tag), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_valid_async", 64'(cdb_valid), 64'(0));
        check("t6_busy_async",  64'(busy),      64'(0));
        check("t6_err_async",   64'(err_tag),   64'(0));
        req_valid = '0;
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("t6_ready_after", 64'(req_ready), 64'(4'hF));
        set_req(2, 8'h88, 32'h55);
        cycle();
        req_valid = '0;
        cycle();
        check("t6_post_src",  64'(cdb_src),  64'(2));
        check("t6_post_data", 64'(cdb_data), 64'(32'h55));
        cycle();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
